// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// The controller side is the master: it observes Opcode/Zero/MemReady and
// drives every datapath strobe and mux select.
interface multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Opcode;
    logic               Zero;
    logic               MemReady;
    logic               MemReq;
    logic               MemWrite;
    logic               IorD;
    logic               IRWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               ExtOp;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSrc;
    logic               PCEn;
    logic               IllegalOp;
    logic [STATE_W-1:0] StateOut;

    modport master (
        input  Opcode, Zero, MemReady,
        output MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSrc, PCEn, IllegalOp, StateOut
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSrc, PCEn, IllegalOp, StateOut
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
//
// state   | code | meaning
// IDLE    |  0   | post-reset, all strobes off
// FETCH   |  1   | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE  |  2   | register read, branch target precompute, dispatch on opcode
// MEMADR  |  3   | lw/sw effective address
// MEMRD   |  4   | load data read, waits on MemReady
// MEMWB   |  5   | load writeback to rt
// MEMWR   |  6   | store, write strobe held through wait states
// RTYPEEX |  7   | R-type ALU op
// RTYPEWB |  8   | R-type writeback to rd
// BEQEX   |  9   | compare, PC <= ALUOut when Zero
// IMMEX   | 10   | addi/andi/ori ALU op
// IMMWB   | 11   | immediate writeback to rt
// JEX     | 12   | jump
//
// State-only outputs are registered from the next state so they line up with
// state_q and clear asynchronously on reset. IRWrite, PCEn and IllegalOp depend
// on inputs within the cycle and are decoded combinationally from state_q.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        RTYPEEX = 4'd7,
        RTYPEWB = 4'd8,
        BEQEX   = 4'd9,
        IMMEX   = 4'd10,
        IMMWB   = 4'd11,
        JEX     = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_write_q, mem_write_d;
    logic       iord_q, iord_d;
    logic       reg_dst_q, reg_dst_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       reg_write_q, reg_write_d;
    logic       alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic       ext_op_q, ext_op_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic [1:0] pc_src_q, pc_src_d;
    logic       op_known;

    // Next-state selection and output decode of the state being entered.
    always_comb begin
        op_known = (bus.Opcode == OP_RTYPE) || (bus.Opcode == OP_J)    ||
                   (bus.Opcode == OP_BEQ)   || (bus.Opcode == OP_ADDI) ||
                   (bus.Opcode == OP_ANDI)  || (bus.Opcode == OP_ORI)  ||
                   (bus.Opcode == OP_LW)    || (bus.Opcode == OP_SW);

        state_d = FETCH;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW:             state_d = MEMADR;
                    OP_RTYPE:                 state_d = RTYPEEX;
                    OP_BEQ:                   state_d = BEQEX;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = IMMEX;
                    OP_J:                     state_d = JEX;
                    default:                  state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (bus.Opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = bus.MemReady ? MEMWB : MEMRD;
            MEMWR:   state_d = bus.MemReady ? FETCH : MEMWR;
            RTYPEEX: state_d = RTYPEWB;
            IMMEX:   state_d = IMMWB;
            default: state_d = FETCH;
        endcase

        mem_req_d    = 1'b0;
        mem_write_d  = 1'b0;
        iord_d       = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        ext_op_d     = 1'b0;
        alu_op_d     = 2'b00;
        pc_src_d     = 2'b00;
        case (state_d)
            FETCH: begin
                mem_req_d   = 1'b1;
                alu_src_b_d = 2'b01;
            end
            DECODE: begin
                alu_src_b_d = 2'b11;
                ext_op_d    = 1'b1;
            end
            MEMADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
                ext_op_d    = 1'b1;
            end
            MEMRD: begin
                mem_req_d = 1'b1;
                iord_d    = 1'b1;
            end
            MEMWB: begin
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
            end
            MEMWR: begin
                mem_req_d   = 1'b1;
                iord_d      = 1'b1;
                mem_write_d = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            RTYPEWB: begin
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
            end
            BEQEX: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b01;
                pc_src_d    = 2'b01;
            end
            IMMEX: begin
                // Opcode is still the DECODE-cycle instruction; IR is stable here.
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
                ext_op_d    = (bus.Opcode == OP_ADDI);
                alu_op_d    = (bus.Opcode == OP_ADDI) ? 2'b00 : 2'b11;
            end
            IMMWB: begin
                reg_write_d = 1'b1;
            end
            JEX: begin
                pc_src_d = 2'b10;
            end
            default: ;
        endcase
    end

    // State register with registered Moore outputs; reset drops every strobe at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            iord_q       <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_a_q  <= 1'b0;
            alu_src_b_q  <= 2'b00;
            ext_op_q     <= 1'b0;
            alu_op_q     <= 2'b00;
            pc_src_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            iord_q       <= iord_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            ext_op_q     <= ext_op_d;
            alu_op_q     <= alu_op_d;
            pc_src_q     <= pc_src_d;
        end
    end

    // Input-qualified strobes: instruction load/PC+4 on memory ready, branch on Zero.
    always_comb begin
        bus.IRWrite   = (state_q == FETCH) && bus.MemReady;
        bus.PCEn      = ((state_q == FETCH) && bus.MemReady) || (state_q == JEX) ||
                        ((state_q == BEQEX) && bus.Zero);
        bus.IllegalOp = (state_q == DECODE) && !op_known;
    end

    assign bus.MemReq   = mem_req_q;
    assign bus.MemWrite = mem_write_q;
    assign bus.IorD     = iord_q;
    assign bus.RegDst   = reg_dst_q;
    assign bus.MemtoReg = mem_to_reg_q;
    assign bus.RegWrite = reg_write_q;
    assign bus.ALUSrcA  = alu_src_a_q;
    assign bus.ALUSrcB  = alu_src_b_q;
    assign bus.ExtOp    = ext_op_q;
    assign bus.ALUOp    = alu_op_q;
    assign bus.PCSrc    = pc_src_q;
    assign bus.StateOut = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for the multicycle MIPS controller: walks each instruction
// class cycle by cycle against hand-written state codes and output vectors.
module tb_multicycle_control;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Expected output vector, fields in the order of obs() below.
    function automatic logic [16:0] ov(input logic mreq, input logic mw, input logic iord,
                                       input logic irw, input logic rd, input logic mtr,
                                       input logic rw, input logic srca, input logic [1:0] srcb,
                                       input logic ext, input logic [1:0] aop,
                                       input logic [1:0] pcs, input logic pcen, input logic ill);
        return {mreq, mw, iord, irw, rd, mtr, rw, srca, srcb, ext, aop, pcs, pcen, ill};
    endfunction

    function automatic logic [16:0] obs();
        return {bus.MemReq, bus.MemWrite, bus.IorD, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.ALUOp, bus.PCSrc,
                bus.PCEn, bus.IllegalOp};
    endfunction

    // One cycle: drive inputs at the falling edge, then check state and outputs.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] exp,
                       input logic mr, input logic z);
        @(negedge clk);
        bus.MemReady = mr;
        bus.Zero     = z;
        #1;
        check({tag, ".state"}, {28'd0, bus.StateOut}, {28'd0, st});
        check({tag, ".outs"}, {15'd0, obs()}, {15'd0, exp});
    endtask

    logic [16:0] e_zero, e_fetch, e_fwait, e_dec, e_decill, e_madr, e_mrd, e_mwb, e_mwr;
    logic [16:0] e_rex, e_rwb, e_beq1, e_beq0, e_addi, e_andi, e_iwb, e_jex;

    initial begin
        checks = 0;
        errors = 0;
        //               mrq mw io irw rd mtr rw sa  sb    ex aop   pcs   pce il
        e_zero   = ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        e_fetch  = ov(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0);
        e_fwait  = ov(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0);
        e_dec    = ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 2'b00, 2'b00, 0, 0);
        e_decill = ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 2'b00, 2'b00, 0, 1);
        e_madr   = ov(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 2'b00, 0, 0);
        e_mrd    = ov(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        e_mwb    = ov(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        e_mwr    = ov(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        e_rex    = ov(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b10, 2'b00, 0, 0);
        e_rwb    = ov(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        e_beq1   = ov(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 2'b01, 1, 0);
        e_beq0   = ov(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 2'b01, 0, 0);
        e_addi   = ov(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 2'b00, 0, 0);
        e_andi   = ov(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b11, 2'b00, 0, 0);
        e_iwb    = ov(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        e_jex    = ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 1, 0);

        reset        = 1'b1;
        bus.Opcode   = 6'b100011;
        bus.MemReady = 1'b0;
        bus.Zero     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.state", {28'd0, bus.StateOut}, 32'd0);
        check("rst.outs", {15'd0, obs()}, {15'd0, e_zero});

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle.state", {28'd0, bus.StateOut}, 32'd0);

        // lw, no wait states: 1,2,3,4,5
        bus.Opcode = 6'b100011;
        cyc("lw.fetch",  4'd1, e_fetch, 1, 0);
        cyc("lw.dec",    4'd2, e_dec,   1, 0);
        cyc("lw.madr",   4'd3, e_madr,  1, 0);
        cyc("lw.mrd",    4'd4, e_mrd,   1, 0);
        cyc("lw.mwb",    4'd5, e_mwb,   1, 0);

        // sw with two fetch wait cycles and three store wait cycles
        bus.Opcode = 6'b101011;
        cyc("sw.fwait0", 4'd1, e_fwait, 0, 0);
        cyc("sw.fwait1", 4'd1, e_fwait, 0, 0);
        cyc("sw.fetch",  4'd1, e_fetch, 1, 0);
        cyc("sw.dec",    4'd2, e_dec,   1, 0);
        cyc("sw.madr",   4'd3, e_madr,  1, 0);
        cyc("sw.mwr0",   4'd6, e_mwr,   0, 0);
        cyc("sw.mwr1",   4'd6, e_mwr,   0, 0);
        cyc("sw.mwr2",   4'd6, e_mwr,   0, 0);
        cyc("sw.mwr3",   4'd6, e_mwr,   1, 0);

        // R-type
        bus.Opcode = 6'b000000;
        cyc("r.fetch",   4'd1, e_fetch, 1, 0);
        cyc("r.dec",     4'd2, e_dec,   1, 0);
        cyc("r.ex",      4'd7, e_rex,   1, 0);
        cyc("r.wb",      4'd8, e_rwb,   1, 0);

        // beq taken then not taken
        bus.Opcode = 6'b000100;
        cyc("beq1.fetch", 4'd1, e_fetch, 1, 0);
        cyc("beq1.dec",   4'd2, e_dec,   1, 0);
        cyc("beq1.ex",    4'd9, e_beq1,  1, 1);
        cyc("beq0.fetch", 4'd1, e_fetch, 1, 0);
        cyc("beq0.dec",   4'd2, e_dec,   1, 0);
        cyc("beq0.ex",    4'd9, e_beq0,  1, 0);

        // andi zero-extends, addi sign-extends
        bus.Opcode = 6'b001100;
        cyc("andi.fetch", 4'd1,  e_fetch, 1, 0);
        cyc("andi.dec",   4'd2,  e_dec,   1, 0);
        cyc("andi.ex",    4'd10, e_andi,  1, 0);
        cyc("andi.wb",    4'd11, e_iwb,   1, 0);
        bus.Opcode = 6'b001000;
        cyc("addi.fetch", 4'd1,  e_fetch, 1, 0);
        cyc("addi.dec",   4'd2,  e_dec,   1, 0);
        cyc("addi.ex",    4'd10, e_addi,  1, 0);
        cyc("addi.wb",    4'd11, e_iwb,   1, 0);

        // ori shares the andi execute encoding
        bus.Opcode = 6'b001101;
        cyc("ori.fetch",  4'd1,  e_fetch, 1, 0);
        cyc("ori.dec",    4'd2,  e_dec,   1, 0);
        cyc("ori.ex",     4'd10, e_andi,  1, 0);
        cyc("ori.wb",     4'd11, e_iwb,   1, 0);

        // jump
        bus.Opcode = 6'b000010;
        cyc("j.fetch",   4'd1,  e_fetch, 1, 0);
        cyc("j.dec",     4'd2,  e_dec,   1, 0);
        cyc("j.ex",      4'd12, e_jex,   1, 0);

        // illegal opcode: single IllegalOp pulse, straight back to FETCH
        bus.Opcode = 6'b111111;
        cyc("ill.fetch", 4'd1, e_fetch,  1, 0);
        cyc("ill.dec",   4'd2, e_decill, 1, 0);
        cyc("ill.back",  4'd1, e_fetch,  1, 0);

        // reset in the middle of a store
        bus.Opcode = 6'b101011;
        cyc("swr.dec",   4'd2, e_dec,  1, 0);
        cyc("swr.madr",  4'd3, e_madr, 1, 0);
        cyc("swr.mwr",   4'd6, e_mwr,  0, 0);
        @(negedge clk);
        #1;
        check("swr.mwr_hold", {31'd0, bus.MemWrite}, 32'd1);
        reset = 1'b1;
        #1;
        check("swr.rst_state", {28'd0, bus.StateOut}, 32'd0);
        check("swr.rst_outs", {15'd0, obs()}, {15'd0, e_zero});
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("swr.idle", {28'd0, bus.StateOut}, 32'd0);
        check("swr.idle_outs", {15'd0, obs()}, {15'd0, e_zero});
        cyc("swr.refetch", 4'd1, e_fetch, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback over shared ALU, memory and register file.
- Drives the sign-extension unit through ExtOp: sign-extend for lw/sw/addi/beq, zero-extend for andi/ori.
- Supports wait-stated memory via a MemReady handshake.

Parameters:
- STATE_W, 4, width of state register and StateOut
- (opcodes fixed, not parameters) lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, andi 001100, ori 001101, j 000010

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Opcode  in  6  Instr[31:26] from instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes current access this cycle
- MemReq  out  1  memory access request
- MemWrite  out  1  memory write strobe
- IorD  out  1  0 = PC address, 1 = ALUOut address
- IRWrite  out  1  instruction register load
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = Data register
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = ExtImm, 11 = ExtImm<<2
- ExtOp  out  1  1 = sign-extend Imm[15:0], 0 = zero-extend
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 logic by opcode
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PCWrite | (Branch & Zero)
- IllegalOp  out  1  one-cycle pulse on unknown opcode
- StateOut  out  4  current state (debug)

Behaviour:
- Moore FSM. All outputs decode from state only, except IRWrite, PCEn and the MemReady-qualified terms. Outputs not listed for a state are 0.
- Reset: async to IDLE(0). All outputs 0 while in reset and in IDLE. IDLE -> FETCH unconditionally on the next clock.
- Reset asserted mid-instruction: immediate IDLE, no partial writes. RegWrite, MemWrite and PCEn drop to 0 combinationally.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RTYPEEX 7, RTYPEWB 8, BEQEX 9, IMMEX 10, IMMWB 11, JEX 12. Codes 13–15 -> FETCH.
- FETCH:
  - Outputs: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite = PCEn = MemReady.
  - Holds in FETCH while MemReady=0; -> DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=00 (branch target precompute).
  - Next state by Opcode: lw/sw -> MEMADR; R -> RTYPEEX; beq -> BEQEX; addi/andi/ori -> IMMEX; j -> JEX.
  - Any other opcode: IllegalOp=1 this cycle, -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemReq=1, IorD=1. Hold until MemReady, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. -> FETCH.
- MEMWR:
  - Outputs: MemReq=1, IorD=1, MemWrite=1, held for every wait cycle.
  - Hold until MemReady, then -> FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RTYPEWB.
- RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1. -> FETCH.
- BEQEX:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 (internal).
  - PCEn = Zero. -> FETCH.
- IMMEX:
  - ALUSrcA=1, ALUSrcB=10.
  - addi: ExtOp=1, ALUOp=00. andi/ori: ExtOp=0, ALUOp=11.
  - -> IMMWB.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1. -> FETCH.
- JEX: PCSrc=10, PCEn=1. -> FETCH.
- Opcode is sampled each cycle from the IR; IR is stable outside FETCH.
- Cycle counts with zero wait states: lw 5, sw 4, R 4, addi/andi/ori 4, beq 3, j 3. Each MemReady=0 cycle adds 1.

Test Plan:
- reset=1 in mid-MEMWR with MemWrite=1 -> same cycle StateOut=0, all outputs 0. After release: 1 clock in IDLE, then FETCH.
- lw (100011), MemReady tied 1 -> states 1,2,3,4,5,1. ExtOp=1 in DECODE and MEMADR; RegWrite=1 only in MEMWB with MemtoReg=1.
- sw (101011), MemReady low 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles. -> FETCH after the MemReady=1 cycle; RegWrite never 1.
- FETCH with MemReady=0 for 2 cycles -> state stays 1, IRWrite=PCEn=0; asserted only on the MemReady=1 cycle.
- beq (000100): Zero=1 -> PCEn=1 with PCSrc=01 in BEQEX. Zero=0 -> PCEn=0. Both take 3 cycles.
- andi (001100) -> IMMEX ExtOp=0, ALUOp=11. addi (001000) -> ExtOp=1, ALUOp=00. Opcode 111111 -> IllegalOp pulse 1 cycle, back to FETCH, no writes.
